// File: rtl/weight_tile_addr_gen_pkg.sv
// Shared types and defaults for the tiled weight-address generators.
// TILE_CEIL expects TILE and LOG2 to be in scope at the point of use.
`ifndef WEIGHT_TILE_ADDR_GEN_PKG_SV
`define WEIGHT_TILE_ADDR_GEN_PKG_SV
`define TILE_CEIL(n) (((n) + TILE - 1) >> LOG2)

package weight_tile_addr_gen_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DIM_W  = 12;
    localparam int DEF_TILE   = 8;
    localparam int DEF_REP_W  = 8;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        FIN  = 3'b100
    } state_e;

endpackage

`endif

// File: rtl/weight_tile_addr_gen_walk_cnt.sv
// Cascaded ec/er/tc/rep/tr walk counters; exports next-beat values and carry flags.
module tile_walk_cnt #(
    parameter int TILE  = 8,
    parameter int CNT_W = 9,
    parameter int REP_W = 8,
    localparam int LOG2 = $clog2(TILE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_adv,
    input  logic [CNT_W-1:0] i_tc_max,
    input  logic [REP_W-1:0] i_rep_max,
    input  logic [CNT_W-1:0] i_tr_max,
    output logic [LOG2-1:0]  o_ec_nxt,
    output logic [LOG2-1:0]  o_er_nxt,
    output logic [CNT_W-1:0] o_tc_nxt,
    output logic [REP_W-1:0] o_rep_nxt,
    output logic [CNT_W-1:0] o_tr_nxt,
    output logic             o_ec_wrap,
    output logic             o_er_wrap,
    output logic             o_rep_wrap
);

    logic [LOG2-1:0]  ec_q, ec_d, er_q, er_d;
    logic [CNT_W-1:0] tc_q, tc_d, tr_q, tr_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             ec_wrap_s, er_wrap_s, tc_wrap_s, rep_wrap_s, tr_wrap_s;

    // Carry chain: a level wraps only when it and every inner level are at their maxima.
    always_comb begin
        ec_wrap_s  = &ec_q;
        er_wrap_s  = ec_wrap_s && (&er_q);
        tc_wrap_s  = er_wrap_s && (tc_q == i_tc_max);
        rep_wrap_s = tc_wrap_s && (rep_q == i_rep_max);
        tr_wrap_s  = rep_wrap_s && (tr_q == i_tr_max);
    end

    // Next counter values on clear or advance.
    always_comb begin
        ec_d  = ec_q;
        er_d  = er_q;
        tc_d  = tc_q;
        rep_d = rep_q;
        tr_d  = tr_q;
        if (i_clr) begin
            ec_d  = LOG2'(0);
            er_d  = LOG2'(0);
            tc_d  = CNT_W'(0);
            rep_d = REP_W'(0);
            tr_d  = CNT_W'(0);
        end else if (i_adv) begin
            ec_d  = ec_wrap_s  ? LOG2'(0)  : ec_q + LOG2'(1);
            er_d  = er_wrap_s  ? LOG2'(0)  : (ec_wrap_s  ? er_q + LOG2'(1)   : er_q);
            tc_d  = tc_wrap_s  ? CNT_W'(0) : (er_wrap_s  ? tc_q + CNT_W'(1)  : tc_q);
            rep_d = rep_wrap_s ? REP_W'(0) : (tc_wrap_s  ? rep_q + REP_W'(1) : rep_q);
            tr_d  = tr_wrap_s  ? CNT_W'(0) : (rep_wrap_s ? tr_q + CNT_W'(1)  : tr_q);
        end else begin
            ec_d = ec_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ec_q  <= LOG2'(0);
            er_q  <= LOG2'(0);
            tc_q  <= CNT_W'(0);
            rep_q <= REP_W'(0);
            tr_q  <= CNT_W'(0);
        end else begin
            ec_q  <= ec_d;
            er_q  <= er_d;
            tc_q  <= tc_d;
            rep_q <= rep_d;
            tr_q  <= tr_d;
        end
    end

    assign o_ec_nxt   = ec_d;
    assign o_er_nxt   = er_d;
    assign o_tc_nxt   = tc_d;
    assign o_rep_nxt  = rep_d;
    assign o_tr_nxt   = tr_d;
    assign o_ec_wrap  = ec_wrap_s;
    assign o_er_wrap  = er_wrap_s;
    assign o_rep_wrap = rep_wrap_s;

endmodule

// File: rtl/weight_tile_addr_gen.sv
// Tile-by-tile weight SRAM address generator with start/done control and a
// valid/ready stall handshake; addresses come from accumulators, not a multiplier.
module weight_tile_addr_gen
    import weight_tile_addr_gen_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIM_W  = DEF_DIM_W,
    parameter int TILE   = DEF_TILE,
    parameter int REP_W  = DEF_REP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [DIM_W-1:0]  cfg_cols,
    input  logic [DIM_W-1:0]  cfg_stride,
    input  logic [REP_W-1:0]  cfg_reuse,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_valid,
    output logic              o_pad,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam int LOG2  = $clog2(TILE);
    localparam int CNT_W = DIM_W - LOG2;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, row_base_q, row_base_d, tile_base_q, tile_base_d;
    logic [DIM_W-1:0]  rows_q, rows_d, cols_q, cols_d, stride_q, stride_d;
    logic [CNT_W-1:0]  tc_max_q, tc_max_d, tr_max_q, tr_max_d;
    logic [REP_W-1:0]  rep_max_q, rep_max_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d, pad_q, pad_d, last_q, last_d;

    logic              clr_s, adv_s, load_s, finish_s;
    logic [DIM_W:0]    row_tiles_s, col_tiles_s;
    logic [CNT_W-1:0]  tr_max_s, tc_max_s;
    logic [REP_W-1:0]  rep_max_s;
    logic [ADDR_W-1:0] stride_ext_s, addr_nxt_s;
    logic [LOG2-1:0]   ec_nxt_s, er_nxt_s;
    logic [CNT_W-1:0]  tc_nxt_s, tr_nxt_s;
    logic [REP_W-1:0]  rep_nxt_s;
    logic [DIM_W-1:0]  r_nxt_s, c_nxt_s;
    logic              ec_wrap_s, er_wrap_s, rep_wrap_s, pad_nxt_s, last_nxt_s;

    // Counter limits from the raw config; only latched when a start is accepted.
    always_comb begin
        row_tiles_s  = (DIM_W+1)'(`TILE_CEIL({1'b0, cfg_rows}));
        col_tiles_s  = (DIM_W+1)'(`TILE_CEIL({1'b0, cfg_cols}));
        tr_max_s     = CNT_W'(row_tiles_s - (DIM_W+1)'(1));
        tc_max_s     = CNT_W'(col_tiles_s - (DIM_W+1)'(1));
        rep_max_s    = (cfg_reuse == REP_W'(0)) ? REP_W'(0) : cfg_reuse - REP_W'(1);
        stride_ext_s = ADDR_W'(stride_q);
    end

    // FSM, config latch and row-base accumulators.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        stride_d    = stride_q;
        tc_max_d    = tc_max_q;
        tr_max_d    = tr_max_q;
        rep_max_d   = rep_max_q;
        row_base_d  = row_base_q;
        tile_base_d = tile_base_q;
        clr_s       = 1'b0;
        adv_s       = 1'b0;
        load_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    base_d      = cfg_base;
                    rows_d      = cfg_rows;
                    cols_d      = cfg_cols;
                    stride_d    = cfg_stride;
                    tc_max_d    = tc_max_s;
                    tr_max_d    = tr_max_s;
                    rep_max_d   = rep_max_s;
                    row_base_d  = cfg_base;
                    tile_base_d = cfg_base;
                    clr_s       = 1'b1;
                    if ((cfg_rows == DIM_W'(0)) || (cfg_cols == DIM_W'(0))) begin
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                        load_s  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (valid_q && i_ready) begin
                    if (last_q) begin
                        state_d  = FIN;
                        finish_s = 1'b1;
                    end else begin
                        adv_s  = 1'b1;
                        load_s = 1'b1;
                        // Tile-column and reuse advances rewind to the saved tile-row start.
                        if (!ec_wrap_s) begin
                            row_base_d = row_base_q;
                        end else if (!er_wrap_s) begin
                            row_base_d = row_base_q + stride_ext_s;
                        end else if (!rep_wrap_s) begin
                            row_base_d = tile_base_q;
                        end else begin
                            row_base_d  = row_base_q + stride_ext_s;
                            tile_base_d = row_base_q + stride_ext_s;
                        end
                    end
                end else begin
                    state_d = RUN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                finish_s = 1'b1;
            end
        endcase
    end

    tile_walk_cnt #(
        .TILE  (TILE),
        .CNT_W (CNT_W),
        .REP_W (REP_W)
    ) u_walk (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (clr_s),
        .i_adv      (adv_s),
        .i_tc_max   (tc_max_q),
        .i_rep_max  (rep_max_q),
        .i_tr_max   (tr_max_q),
        .o_ec_nxt   (ec_nxt_s),
        .o_er_nxt   (er_nxt_s),
        .o_tc_nxt   (tc_nxt_s),
        .o_rep_nxt  (rep_nxt_s),
        .o_tr_nxt   (tr_nxt_s),
        .o_ec_wrap  (ec_wrap_s),
        .o_er_wrap  (er_wrap_s),
        .o_rep_wrap (rep_wrap_s)
    );

    // Next beat: TILE is a power of two, so coordinates are plain concatenations.
    always_comb begin
        r_nxt_s    = {tr_nxt_s, er_nxt_s};
        c_nxt_s    = {tc_nxt_s, ec_nxt_s};
        pad_nxt_s  = (r_nxt_s >= rows_d) || (c_nxt_s >= cols_d);
        addr_nxt_s = pad_nxt_s ? ADDR_W'(0) : row_base_d + ADDR_W'(c_nxt_s);
        last_nxt_s = (&ec_nxt_s) && (&er_nxt_s) && (tc_nxt_s == tc_max_d) &&
                     (rep_nxt_s == rep_max_d) && (tr_nxt_s == tr_max_d);
        valid_d    = valid_q;
        addr_d     = addr_q;
        pad_d      = pad_q;
        last_d     = last_q;
        if (load_s) begin
            valid_d = 1'b1;
            addr_d  = addr_nxt_s;
            pad_d   = pad_nxt_s;
            last_d  = last_nxt_s;
        end else if (finish_s) begin
            valid_d = 1'b0;
            addr_d  = ADDR_W'(0);
            pad_d   = 1'b0;
            last_d  = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State, config and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= ADDR_W'(0);
            rows_q      <= DIM_W'(0);
            cols_q      <= DIM_W'(0);
            stride_q    <= DIM_W'(0);
            tc_max_q    <= CNT_W'(0);
            tr_max_q    <= CNT_W'(0);
            rep_max_q   <= REP_W'(0);
            row_base_q  <= ADDR_W'(0);
            tile_base_q <= ADDR_W'(0);
            addr_q      <= ADDR_W'(0);
            valid_q     <= 1'b0;
            pad_q       <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            stride_q    <= stride_d;
            tc_max_q    <= tc_max_d;
            tr_max_q    <= tr_max_d;
            rep_max_q   <= rep_max_d;
            row_base_q  <= row_base_d;
            tile_base_q <= tile_base_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            pad_q       <= pad_d;
            last_q      <= last_d;
        end
    end

    assign o_addr  = addr_q;
    assign o_valid = valid_q;
    assign o_pad   = pad_q;
    assign o_last  = last_q;
    assign o_busy  = (state_q != IDLE);
    assign o_done  = (state_q == FIN);

endmodule

// File: tb/tb_weight_tile_addr_gen.sv
// Scoreboard bench for weight_tile_addr_gen: a stimulus process queues expected
// beats per job, a monitor pops and compares on every accepted beat.
module tb_weight_tile_addr_gen;

    localparam int TILE = 8;

    typedef struct packed {
        logic [15:0] addr;
        logic        pad;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] cfg_base = 16'h0;
    logic [11:0] cfg_rows = 12'h0, cfg_cols = 12'h0, cfg_stride = 12'h0;
    logic [7:0]  cfg_reuse = 8'h0;
    logic        i_ready = 1'b1;
    logic [15:0] o_addr;
    logic        o_valid, o_pad, o_last, o_busy, o_done;

    int          total = 0;
    int          bad = 0;
    beat_t       sb[$];
    logic [15:0] cap_addr [0:1023];
    logic        cap_pad  [0:1023];
    logic        cap_last [0:1023];
    int          beat_n = 0;
    bit          rnd_ready = 1'b0;
    bit          zero_due = 1'b0;

    weight_tile_addr_gen dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .cfg_base   (cfg_base),
        .cfg_rows   (cfg_rows),
        .cfg_cols   (cfg_cols),
        .cfg_stride (cfg_stride),
        .cfg_reuse  (cfg_reuse),
        .i_ready    (i_ready),
        .o_addr     (o_addr),
        .o_valid    (o_valid),
        .o_pad      (o_pad),
        .o_last     (o_last),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference walk: direct r*stride arithmetic over the nested tile loops.
    task automatic push_model(input int rows, input int cols, input int stride,
                              input int base, input int reuse);
        int    trn, tcn, rp, r, c;
        beat_t b;
        trn = (rows + TILE - 1) / TILE;
        tcn = (cols + TILE - 1) / TILE;
        rp  = (reuse == 0) ? 1 : reuse;
        for (int tr = 0; tr < trn; tr++)
            for (int rep = 0; rep < rp; rep++)
                for (int tc = 0; tc < tcn; tc++)
                    for (int er = 0; er < TILE; er++)
                        for (int ec = 0; ec < TILE; ec++) begin
                            r = tr * TILE + er;
                            c = tc * TILE + ec;
                            b.pad  = (r >= rows) || (c >= cols);
                            b.addr = b.pad ? 16'h0 : 16'((base + r * stride + c) % 65536);
                            b.last = (tr == trn - 1) && (rep == rp - 1) && (tc == tcn - 1) &&
                                     (er == TILE - 1) && (ec == TILE - 1);
                            sb.push_back(b);
                        end
    endtask

    task automatic start_job(input int rows, input int cols, input int stride,
                             input int base, input int reuse);
        push_model(rows, cols, stride, base, reuse);
        beat_n = 0;
        @(posedge clk);
        #1;
        cfg_rows   = 12'(rows);
        cfg_cols   = 12'(cols);
        cfg_stride = 12'(stride);
        cfg_base   = 16'(base);
        cfg_reuse  = 8'(reuse);
        i_start    = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // Consumer ready: always on, or a coin flip each cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: beat scoreboard, stall hold and o_done timing.
    initial begin
        beat_t e;
        beat_t held;
        bit    held_v;
        bit    pend;
        held_v = 1'b0;
        pend   = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
                pend   = 1'b0;
            end else begin
                check("done_timing", 32'(o_done), 32'(pend));
                if (held_v)
                    check("stall_hold", 32'({o_valid, o_addr, o_pad, o_last}), 32'({1'b1, held}));
                held_v = o_valid && !i_ready;
                held   = {o_addr, o_pad, o_last};
                if (o_valid && i_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_beat: got addr %0h expected no beat", o_addr);
                    end else begin
                        e = sb.pop_front();
                        check("beat", 32'({o_addr, o_pad, o_last}), 32'(e));
                    end
                    if (beat_n < 1024) begin
                        cap_addr[beat_n] = o_addr;
                        cap_pad[beat_n]  = o_pad;
                        cap_last[beat_n] = o_last;
                    end
                    beat_n++;
                end
                pend = (o_valid && i_ready && o_last) || (zero_due && i_start && !o_busy);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({o_valid, o_addr, o_pad, o_last, o_busy, o_done}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 8x8 single tile, dense
        start_job(8, 8, 8, 0, 1);
        wait_done("t1");
        check("t1_beats", 32'(beat_n), 32'd64);
        for (int i = 0; i < 64; i++) check("t1_addr", 32'(cap_addr[i]), 32'(i));
        check("t1_last", 32'(cap_last[63]), 32'd1);
        check("t1_not_last", 32'(cap_last[62]), 32'd0);

        // 10x12 with padding, 2x2 tiles
        start_job(10, 12, 16, 16'h100, 1);
        wait_done("t2");
        check("t2_beats", 32'(beat_n), 32'd256);
        check("t2_r9c11", 32'({cap_addr[203], cap_pad[203]}), 32'({16'h019B, 1'b0}));
        check("t2_r10c0", 32'({cap_addr[144], cap_pad[144]}), 32'({16'h0000, 1'b1}));
        check("t2_r0c12", 32'({cap_addr[68], cap_pad[68]}), 32'({16'h0000, 1'b1}));
        check("t2_corner", 32'({cap_pad[255], cap_last[255]}), 32'({1'b1, 1'b1}));

        // reuse 3 over two column tiles
        start_job(8, 16, 16, 0, 3);
        wait_done("t3");
        check("t3_beats", 32'(beat_n), 32'd384);
        check("t3_tc1", 32'(cap_addr[64]), 32'd8);
        check("t3_rep1", 32'(cap_addr[128]), 32'd0);
        check("t3_rep0_end", 32'({cap_addr[127], cap_last[127]}), 32'({16'd127, 1'b0}));
        check("t3_end", 32'({cap_addr[383], cap_last[383]}), 32'({16'd127, 1'b1}));

        // random ready plus a start pulse while busy
        rnd_ready = 1'b1;
        start_job(10, 12, 16, 16'h100, 1);
        repeat (30) @(posedge clk);
        #1;
        cfg_base = 16'h0;
        cfg_rows = 12'd3;
        i_start  = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done("t4");
        rnd_ready = 1'b0;
        check("t4_beats", 32'(beat_n), 32'd256);
        check("t4_r9c11", 32'(cap_addr[203]), 32'h019B);

        // zero rows: FIN only, start held an extra cycle while busy
        beat_n = 0;
        @(posedge clk);
        #1;
        cfg_rows = 12'd0;
        cfg_cols = 12'd8;
        i_start  = 1'b1;
        zero_due = 1'b1;
        @(negedge clk);
        check("t5_idle_pre", 32'(o_busy), 32'd0);
        @(negedge clk);
        check("t5_fin", 32'({o_busy, o_done, o_valid}), 32'({1'b1, 1'b1, 1'b0}));
        @(posedge clk);
        #1;
        i_start  = 1'b0;
        zero_due = 1'b0;
        @(negedge clk);
        check("t5_back_idle", 32'({o_busy, o_valid}), 32'd0);
        repeat (3) @(negedge clk);
        check("t5_no_beats", 32'(beat_n), 32'd0);

        // reuse 0 behaves as 1
        start_job(8, 8, 8, 16'h10, 0);
        wait_done("t6");
        check("t6_beats", 32'(beat_n), 32'd64);
        check("t6_end", 32'({cap_addr[63], cap_last[63]}), 32'({16'h004F, 1'b1}));

        // reset mid-run, then a fresh job
        start_job(8, 8, 8, 16'h40, 1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t7_rst_out", 32'({o_valid, o_addr, o_pad, o_last, o_busy, o_done}), 32'd0);
        @(negedge clk);
        check("t7_rst_hold", 32'({o_valid, o_addr, o_pad, o_last, o_busy, o_done}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        repeat (4) @(negedge clk);
        check("t7_idle", 32'({o_busy, o_valid}), 32'd0);
        start_job(8, 8, 8, 0, 1);
        wait_done("t7");
        check("t7_beats", 32'(beat_n), 32'd64);
        check("t7_first", 32'(cap_addr[0]), 32'd0);
        check("t7_last", 32'(cap_addr[63]), 32'd63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
